// File: rtl/wb_write_arbiter_pkg.sv
// ============================================================================
// Module  : wb_write_arbiter_pkg
// Brief   : Shared register-file constants for the write-back arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_write_arbiter_pkg;
    localparam logic        WR_ENABLE      = 1'b1;
    localparam logic        WR_DISABLE     = 1'b0;
    localparam int          REG_BUS        = 32;
    localparam int          REG_ADDR_BUS   = 5;
    localparam int          REG_NUM        = 32;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
endpackage

`default_nettype wire

// File: rtl/wb_result_fifo.sv
// ============================================================================
// Module  : wb_result_fifo
// Brief   : Parameterised synchronous FIFO for long-latency results.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/wb_write_arbiter.sv
// ============================================================================
// Module  : wb_write_arbiter
// Brief   : Merges pipeline and long-latency results onto the RF write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W     = REG_BUS,
    parameter int ADDR_W     = REG_ADDR_BUS,
    parameter int NUM_REGS   = REG_NUM,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipe_we,
    input  logic [ADDR_W-1:0]   pipe_waddr,
    input  logic [DATA_W-1:0]   pipe_wdata,
    input  logic                lu_valid,
    output logic                lu_ready,
    input  logic [ADDR_W-1:0]   lu_waddr,
    input  logic [DATA_W-1:0]   lu_wdata,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_waddr,
    output logic [NUM_REGS-1:0] pending,
    output logic                wb_stall_req,
    output logic                we,
    output logic [ADDR_W-1:0]   waddr,
    output logic [DATA_W-1:0]   wdata
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                       w_full;
    logic                       w_empty;
    logic [CNT_W-1:0]           w_count;
    logic [ADDR_W+DATA_W-1:0]   w_head;
    logic [ADDR_W-1:0]          w_head_addr;
    logic [DATA_W-1:0]          w_head_data;
    logic                       w_pipe_wr;
    logic                       w_push;
    logic                       w_pop;
    logic [NUM_REGS-1:0]        w_set;
    logic [NUM_REGS-1:0]        w_clr;
    logic                       r_we;
    logic [ADDR_W-1:0]          r_waddr;
    logic [DATA_W-1:0]          r_wdata;
    logic [NUM_REGS-1:0]        r_pending;

    assign w_head_addr  = w_head[ADDR_W+DATA_W-1:DATA_W];
    assign w_head_data  = w_head[DATA_W-1:0];
    assign lu_ready     = (w_count != CNT_W'(FIFO_DEPTH));
    assign wb_stall_req = w_full;
    assign w_push       = lu_valid && lu_ready;
    assign w_pipe_wr    = pipe_we && (pipe_waddr != '0);
    // The pipeline has no backpressure, so the FIFO only drains in its gaps.
    assign w_pop        = !w_pipe_wr && !w_empty;

    wb_result_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({lu_waddr, lu_wdata}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_set[i] = issue_valid && (issue_waddr == ADDR_W'(i));
            w_clr[i] = w_pop && (w_head_addr == ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= WR_DISABLE;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_pipe_wr) begin
            r_we    <= WR_ENABLE;
            r_waddr <= pipe_waddr;
            r_wdata <= pipe_wdata;
        end else if (w_pop && (w_head_addr != '0)) begin
            r_we    <= WR_ENABLE;
            r_waddr <= w_head_addr;
            r_wdata <= w_head_data;
        end else begin
            // Idle slot, or a popped r0 entry that must not reach the file.
            r_we    <= WR_DISABLE;
            r_waddr <= '0;
            r_wdata <= '0;
        end
    end

    assign we      = r_we;
    assign waddr   = r_waddr;
    assign wdata   = r_wdata;
    assign pending = r_pending;
endmodule

`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
// ============================================================================
// Module  : tb_wb_write_arbiter
// Brief   : Self-checking bench: directed vector table, corner sequences, random vs model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_write_arbiter;
    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        issue_valid;
    logic [4:0]  issue_waddr;
    logic [31:0] pending;
    logic        wb_stall_req;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks;
    int failures;

    wb_write_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_waddr   (pipe_waddr),
        .pipe_wdata   (pipe_wdata),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_waddr     (lu_waddr),
        .lu_wdata     (lu_wdata),
        .issue_valid  (issue_valid),
        .issue_waddr  (issue_waddr),
        .pending      (pending),
        .wb_stall_req (wb_stall_req),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        pwe;
        logic [4:0]  pwa;
        logic [31:0] pwd;
        logic        lv;
        logic [4:0]  lwa;
        logic [31:0] lwd;
        logic        iv;
        logic [4:0]  iwa;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_rdy;
        logic [31:0] e_pend;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    vec_t tbl[$];
    ent_t mq[$];
    logic [31:0] mpend;

    function automatic logic [31:0] bit_of(input int n);
        logic [31:0] one;
        one = 32'd1;
        return one << n;
    endfunction

    function automatic vec_t mk(input logic pwe, input int pwa, input logic [31:0] pwd,
                                input logic lv, input int lwa, input logic [31:0] lwd,
                                input logic iv, input int iwa,
                                input logic e_we, input int e_wa, input logic [31:0] e_wd,
                                input logic e_rdy, input logic [31:0] e_pend);
        vec_t v;
        v.pwe = pwe; v.pwa = 5'(pwa); v.pwd = pwd;
        v.lv  = lv;  v.lwa = 5'(lwa); v.lwd = lwd;
        v.iv  = iv;  v.iwa = 5'(iwa);
        v.e_we = e_we; v.e_wa = 5'(e_wa); v.e_wd = e_wd;
        v.e_rdy = e_rdy; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                         input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
                         input logic iv, input logic [4:0] iwa);
        pipe_we = pwe; pipe_waddr = pwa; pipe_wdata = pwd;
        lu_valid = lv; lu_waddr = lwa; lu_wdata = lwd;
        issue_valid = iv; issue_waddr = iwa;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle();

        // Reset state
        do_reset();
        chk("reset_we",    64'(we),           64'd0);
        chk("reset_waddr", 64'(waddr),        64'd0);
        chk("reset_wdata", 64'(wdata),        64'd0);
        chk("reset_ready", 64'(lu_ready),     64'd1);
        chk("reset_stall", 64'(wb_stall_req), 64'd0);
        chk("reset_pend",  64'(pending),      64'd0);

        // Directed table: expected values are the outputs just after each edge.
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0,    1, 5, 32'hDEADBEEF, 1, 0));
        tbl.push_back(mk(1, 0, 32'h55,       0, 0, 0, 0, 0,    0, 0, 0,            1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 9,    0, 0, 0,            1, bit_of(9)));
        tbl.push_back(mk(0, 0, 0,            1, 9, 32'h1234, 0, 0, 0, 0, 0,        1, bit_of(9)));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,    1, 9, 32'h1234,     1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,    0, 0, 0,            1, 0));
        tbl.push_back(mk(1, 1, 32'h1,        1, 10, 32'hA0, 1, 10, 1, 1, 32'h1,    1, bit_of(10)));
        tbl.push_back(mk(1, 2, 32'h2,        1, 11, 32'hB0, 1, 11, 1, 2, 32'h2,    0, bit_of(10) | bit_of(11)));
        tbl.push_back(mk(1, 3, 32'h3,        1, 12, 32'hC0, 0, 0,  1, 3, 32'h3,    0, bit_of(10) | bit_of(11)));
        tbl.push_back(mk(1, 4, 32'h4,        0, 0, 0, 0, 0,    1, 4, 32'h4,        0, bit_of(10) | bit_of(11)));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,    1, 10, 32'hA0,      1, bit_of(11)));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,    1, 11, 32'hB0,      1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,    0, 0, 0,            1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 7,    0, 0, 0,            1, bit_of(7)));
        tbl.push_back(mk(0, 0, 0,            1, 7, 32'h77, 0, 0, 0, 0, 0,          1, bit_of(7)));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 7,    1, 7, 32'h77,       1, bit_of(7)));
        tbl.push_back(mk(0, 0, 0,            1, 0, 32'h99, 0, 0, 0, 0, 0,          1, bit_of(7)));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0,    0, 0, 0,            1, bit_of(7)));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 0,    0, 0, 0,            1, bit_of(7)));
        tbl.push_back(mk(0, 0, 0,            1, 20, 32'h20, 0, 0, 0, 0, 0,         1, bit_of(7)));
        tbl.push_back(mk(1, 0, 32'hFF,       0, 0, 0, 0, 0,    1, 20, 32'h20,      1, bit_of(7)));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].pwe, tbl[i].pwa, tbl[i].pwd, tbl[i].lv, tbl[i].lwa, tbl[i].lwd,
                  tbl[i].iv, tbl[i].iwa);
            tick();
            chk($sformatf("vec%0d_we", i),    64'(we),           64'(tbl[i].e_we));
            chk($sformatf("vec%0d_waddr", i), 64'(waddr),        64'(tbl[i].e_wa));
            chk($sformatf("vec%0d_wdata", i), 64'(wdata),        64'(tbl[i].e_wd));
            chk($sformatf("vec%0d_ready", i), 64'(lu_ready),     64'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_stall", i), 64'(wb_stall_req), 64'(!tbl[i].e_rdy));
            chk($sformatf("vec%0d_pend", i),  64'(pending),      64'(tbl[i].e_pend));
        end

        // Asynchronous reset while the FIFO holds two entries.
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd12);
        tick();
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd13, 32'hC2, 1'b1, 5'd13);
        tick();
        chk("midrst_full_before", 64'(wb_stall_req), 64'd1);
        idle();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_we",    64'(we),           64'd0);
        chk("midrst_pend",  64'(pending),      64'd0);
        chk("midrst_ready", 64'(lu_ready),     64'd1);
        chk("midrst_stall", 64'(wb_stall_req), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("midrst_stale%0d_we", i), 64'(we),      64'd0);
            chk($sformatf("midrst_stale%0d_pend", i), 64'(pending), 64'd0);
        end

        // Pointer wrap: back-to-back push/pop pairs keep order and never fill.
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(k + 1), 32'hA500 + 32'(k), 1'b0, 5'd0);
            else       idle();
            tick();
            if (k > 0) begin
                chk($sformatf("wrap%0d_we", k),    64'(we),    64'd1);
                chk($sformatf("wrap%0d_waddr", k), 64'(waddr), 64'(k));
                chk($sformatf("wrap%0d_wdata", k), 64'(wdata), 64'(32'hA500 + 32'(k - 1)));
            end
            chk($sformatf("wrap%0d_stall", k), 64'(wb_stall_req), 64'd0);
        end

        // Random traffic against a queue-based reference model.
        do_reset();
        mq.delete();
        mpend = '0;
        for (int n = 0; n < 400; n++) begin
            logic        rpwe, rlv, riv, acc, exp_we;
            logic [4:0]  rpwa, rlwa, riwa, exp_wa;
            logic [31:0] rpwd, rlwd, exp_wd;
            ent_t        h;
            rpwe = ($urandom_range(0, 99) < 45);
            rpwa = 5'($urandom_range(0, 15));
            rpwd = $urandom;
            rlv  = ($urandom_range(0, 99) < 55);
            rlwa = 5'($urandom_range(0, 15));
            rlwd = $urandom;
            riv  = ($urandom_range(0, 99) < 30);
            riwa = 5'($urandom_range(0, 15));
            drive(rpwe, rpwa, rpwd, rlv, rlwa, rlwd, riv, riwa);

            acc = rlv && (mq.size() < 2);
            exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
            if (rpwe && rpwa != 0) begin
                exp_we = 1'b1; exp_wa = rpwa; exp_wd = rpwd;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                mpend[h.a] = 1'b0;
                if (h.a != 0) begin
                    exp_we = 1'b1; exp_wa = h.a; exp_wd = h.d;
                end
            end
            if (acc) begin
                h.a = rlwa; h.d = rlwd;
                mq.push_back(h);
            end
            if (riv) mpend[riwa] = 1'b1;
            mpend[0] = 1'b0;

            tick();
            chk("rnd_we",    64'(we),           64'(exp_we));
            chk("rnd_waddr", 64'(waddr),        64'(exp_wa));
            chk("rnd_wdata", 64'(wdata),        64'(exp_wd));
            chk("rnd_pend",  64'(pending),      64'(mpend));
            chk("rnd_ready", 64'(lu_ready),     64'(mq.size() < 2));
            chk("rnd_stall", 64'(wb_stall_req), 64'(mq.size() == 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
